// File: rtl/fetch.sv
// Instruction fetch stage: issues one request at a time to instruction memory and
// hands fetched words to decode, handling stalls, kills and branch redirects.
module fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        invalidate,
  input  logic        branch,
  input  logic [31:0] branch_target,
  output logic [31:0] mem_address,
  output logic        mem_valid,
  input  logic        mem_ready,
  input  logic [31:0] mem_data,
  output logic [31:0] pc_out,
  output logic [31:0] next_pc_out,
  output logic [31:0] instruction_out,
  output logic        valid_out
);

  typedef enum logic [1:0] {FETCH, DISCARD, HOLD} state_t;

  state_t      state, state_d;
  logic [31:0] pc, pc_d;
  logic [31:0] redirect_pc, redirect_pc_d;
  logic [31:0] buf_pc, buf_pc_d;
  logic [31:0] buf_next_pc, buf_next_pc_d;
  logic [31:0] buf_instr, buf_instr_d;
  logic [31:0] pc_out_d, next_pc_out_d, instruction_out_d;
  logic        valid_out_d;
  logic        transfer;
  logic [31:0] pc_plus4;

  // The pc only advances on a consumed transfer, so the in-flight request address
  // in DISCARD is still pc and mem_address can always be driven from it.
  assign mem_valid   = !reset && (state != HOLD);
  assign mem_address = pc;
  assign transfer    = mem_valid && mem_ready;
  assign pc_plus4    = pc + 32'd4;

  always_comb begin
    state_d           = state;
    pc_d              = pc;
    redirect_pc_d     = redirect_pc;
    buf_pc_d          = buf_pc;
    buf_next_pc_d     = buf_next_pc;
    buf_instr_d       = buf_instr;
    pc_out_d          = pc_out;
    next_pc_out_d     = next_pc_out;
    instruction_out_d = instruction_out;
    valid_out_d       = valid_out;

    case (state)
      FETCH: begin
        if (branch) begin
          valid_out_d = 1'b0;
          if (transfer) begin
            pc_d = branch_target;
          end else begin
            redirect_pc_d = branch_target;
            state_d       = DISCARD;
          end
        end else if (stall) begin
          if (transfer) begin
            buf_pc_d      = pc;
            buf_next_pc_d = pc_plus4;
            buf_instr_d   = mem_data;
            pc_d          = pc_plus4;
            state_d       = HOLD;
          end
        end else if (transfer && !invalidate) begin
          pc_out_d          = pc;
          next_pc_out_d     = pc_plus4;
          instruction_out_d = mem_data;
          valid_out_d       = 1'b1;
          pc_d              = pc_plus4;
        end else begin
          valid_out_d = 1'b0;
        end
      end

      HOLD: begin
        if (branch) begin
          pc_d        = branch_target;
          valid_out_d = 1'b0;
          state_d     = FETCH;
        end else if (!stall) begin
          pc_out_d          = buf_pc;
          next_pc_out_d     = buf_next_pc;
          instruction_out_d = buf_instr;
          valid_out_d       = !invalidate;
          state_d           = FETCH;
        end
      end

      DISCARD: begin
        // A branch arriving while the stale request completes must win over the older redirect.
        if (branch) redirect_pc_d = branch_target;
        if (transfer) begin
          pc_d    = branch ? branch_target : redirect_pc;
          state_d = FETCH;
        end
        if (!stall || branch) valid_out_d = 1'b0;
      end

      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= FETCH;
      pc              <= RESET_VECTOR;
      redirect_pc     <= '0;
      buf_pc          <= '0;
      buf_next_pc     <= '0;
      buf_instr       <= '0;
      pc_out          <= '0;
      next_pc_out     <= '0;
      instruction_out <= '0;
      valid_out       <= 1'b0;
    end else begin
      state           <= state_d;
      pc              <= pc_d;
      redirect_pc     <= redirect_pc_d;
      buf_pc          <= buf_pc_d;
      buf_next_pc     <= buf_next_pc_d;
      buf_instr       <= buf_instr_d;
      pc_out          <= pc_out_d;
      next_pc_out     <= next_pc_out_d;
      instruction_out <= instruction_out_d;
      valid_out       <= valid_out_d;
    end
  end

endmodule
